// File: rtl/axi4_mem_arbiter.sv
// rtl/axi4_mem_arbiter.sv - burst-granular round-robin arbiter sharing one word memory between write and read engines
// Also decodes byte addresses to word indices and flags out-of-range beats.
module axi4_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int MAX_BEATS  = 256,
  parameter int MEM_AW     = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_last,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_dvalid,
  output logic                  rd_oor,
  output logic                  wr_oor,
  output logic                  lock_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [8:0]            MAX_CNT = 9'(MAX_BEATS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR_LOCK, RD_LOCK} state_e;

  state_e          state_q, state_d;
  logic            rr_pref_q, rr_pref_d;
  logic [8:0]      beat_cnt_q, beat_cnt_d;
  logic            rd_pend_q, rd_oor_pend_q;
  logic            live_q;

  logic                  active, beat, beat_last, beat_oor, force_rel;
  logic [ADDR_WIDTH-1:0] beat_addr, word;
  logic [8:0]            cnt_inc;

  // live_q holds grants off for the first cycle after reset releases
  always_comb begin
    active = live_q & ~ARESET;
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (active) begin
      case (state_q)
        IDLE: begin
          if (wr_req && (!rd_req || !rr_pref_q)) wr_gnt = 1'b1;
          else                                   rd_gnt = rd_req;
        end
        WR_LOCK: wr_gnt = wr_req;
        RD_LOCK: rd_gnt = rd_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    beat      = wr_gnt | rd_gnt;
    beat_last = wr_gnt ? wr_last : rd_last;
    beat_addr = wr_gnt ? wr_addr : rd_addr;
    word      = beat_addr >> 2;
    beat_oor  = (word >= DEPTH_W);
    cnt_inc   = beat_cnt_q + 9'd1;
    force_rel = beat & ~beat_last & (cnt_inc == MAX_CNT);

    state_d    = state_q;
    rr_pref_d  = rr_pref_q;
    beat_cnt_d = beat_cnt_q;
    if (beat) begin
      if (beat_last || force_rel) begin
        state_d    = IDLE;
        beat_cnt_d = 9'd0;
        rr_pref_d  = wr_gnt;
      end else begin
        state_d    = wr_gnt ? WR_LOCK : RD_LOCK;
        beat_cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      rr_pref_q     <= 1'b0;
      beat_cnt_q    <= 9'd0;
      rd_pend_q     <= 1'b0;
      rd_oor_pend_q <= 1'b0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_pref_q     <= rr_pref_d;
      beat_cnt_q    <= beat_cnt_d;
      rd_pend_q     <= rd_gnt;
      rd_oor_pend_q <= rd_gnt & beat_oor;
      live_q        <= 1'b1;
    end
  end

  assign lock_err  = force_rel;
  assign wr_oor    = wr_gnt & beat_oor;
  assign mem_en    = beat & ~beat_oor;
  assign mem_we    = wr_gnt & ~beat_oor;
  assign mem_addr  = mem_en ? word[MEM_AW-1:0] : '0;
  assign mem_wdata = mem_we ? wr_data : '0;

  // An out-of-range read still returns a beat, carrying zero data
  assign rd_dvalid = rd_pend_q & ~ARESET;
  assign rd_oor    = rd_dvalid & rd_oor_pend_q;
  assign rd_data   = (rd_dvalid & ~rd_oor_pend_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// tb/tb_axi4_mem_arbiter.sv - randomized and directed bench for axi4_mem_arbiter against a burst-level model
module tb_axi4_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DEPTH = 1024;
  localparam int MAX_BEATS = 256;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          wr_req = 1'b0, wr_last = 1'b0, rd_req = 1'b0, rd_last = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt, rd_gnt, rd_dvalid, rd_oor, wr_oor, lock_err, mem_en, mem_we;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [9:0]    mem_addr;

  always #5 ACLK = ~ACLK;

  axi4_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_dvalid(rd_dvalid), .rd_oor(rd_oor), .wr_oor(wr_oor), .lock_err(lock_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory the arbiter drives; one-cycle read latency
  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge ACLK) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // Burst-level reference model
  int            m_owner = 0;   // 0 none, 1 write, 2 read
  int            m_pref = 0;    // 0 write preferred, 1 read preferred
  int            m_beats = 0;
  bit            m_live = 0, m_rd_pend = 0, m_rd_oor_pend = 0;
  logic [DW-1:0] m_rd_val = '0;
  logic [DW-1:0] shadow [int];
  int            m_word;
  bit            m_oor, m_last, m_beat;

  logic          exp_wr_gnt, exp_rd_gnt, exp_rd_dvalid, exp_rd_oor, exp_wr_oor, exp_lock_err, exp_mem_en, exp_mem_we;
  logic [9:0]    exp_mem_addr;
  logic [DW-1:0] exp_mem_wdata, exp_rd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Traffic engines
  int wr_bq[$];
  int rd_bq[$];
  int wr_idx = 0, rd_idx = 0;
  bit wr_hold = 0, rd_hold = 0;

  task automatic model_eval();
    logic [AW-1:0] a;
    exp_wr_gnt = 1'b0;
    exp_rd_gnt = 1'b0;
    if (!ARESET && m_live) begin
      if (m_owner == 1)                            exp_wr_gnt = wr_req;
      else if (m_owner == 2)                       exp_rd_gnt = rd_req;
      else if (wr_req && (!rd_req || m_pref == 0)) exp_wr_gnt = 1'b1;
      else                                         exp_rd_gnt = rd_req;
    end
    m_beat = exp_wr_gnt || exp_rd_gnt;
    a      = exp_wr_gnt ? wr_addr : rd_addr;
    m_word = int'(a) / 4;
    m_oor  = (m_word >= DEPTH);
    m_last = exp_wr_gnt ? wr_last : rd_last;
    exp_mem_en    = m_beat && !m_oor;
    exp_mem_we    = exp_wr_gnt && !m_oor;
    exp_mem_addr  = exp_mem_en ? 10'(m_word) : 10'd0;
    exp_mem_wdata = exp_mem_we ? wr_data : '0;
    exp_wr_oor    = exp_wr_gnt && m_oor;
    exp_lock_err  = m_beat && !m_last && (m_beats + 1 == MAX_BEATS);
    exp_rd_dvalid = !ARESET && m_rd_pend;
    exp_rd_oor    = exp_rd_dvalid && m_rd_oor_pend;
    exp_rd_data   = (exp_rd_dvalid && !m_rd_oor_pend) ? m_rd_val : '0;
  endtask

  task automatic model_commit();
    if (ARESET) begin
      m_owner = 0; m_pref = 0; m_beats = 0;
      m_rd_pend = 0; m_rd_oor_pend = 0; m_live = 0;
    end else begin
      m_live        = 1;
      m_rd_pend     = exp_rd_gnt;
      m_rd_oor_pend = exp_rd_gnt && m_oor;
      if (exp_rd_gnt && !m_oor) m_rd_val = shadow.exists(m_word) ? shadow[m_word] : '0;
      if (exp_mem_we) shadow[m_word] = wr_data;
      if (m_beat) begin
        if (m_last || exp_lock_err) begin
          m_owner = 0; m_beats = 0; m_pref = exp_wr_gnt ? 1 : 0;
        end else begin
          m_owner = exp_wr_gnt ? 1 : 2; m_beats++;
        end
      end
    end
  endtask

  function automatic logic [81:0] act_vec();
    return {wr_gnt, rd_gnt, rd_dvalid, rd_oor, wr_oor, lock_err, mem_en, mem_we, mem_addr, mem_wdata, rd_data};
  endfunction

  function automatic logic [81:0] exp_vec();
    return {exp_wr_gnt, exp_rd_gnt, exp_rd_dvalid, exp_rd_oor, exp_wr_oor, exp_lock_err,
            exp_mem_en, exp_mem_we, exp_mem_addr, exp_mem_wdata, exp_rd_data};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 16'($urandom_range(32'h1000, 32'hFFFF));
    return 16'($urandom_range(0, 32'h0FFF));
  endfunction

  task automatic settle();
    @(negedge ACLK);
    model_eval();
  endtask

  task automatic advance();
    @(posedge ACLK);
    model_eval();
    model_commit();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    wr_req = 0; rd_req = 0; wr_last = 0; rd_last = 0;
    ARESET = 1;
    advance();
    ARESET = 0;
    advance();
  endtask

  task automatic drive_engines();
    wr_req  = (wr_bq.size() > 0) && !wr_hold;
    wr_last = (wr_bq.size() > 0) && (wr_idx == wr_bq[0] - 1);
    rd_req  = (rd_bq.size() > 0) && !rd_hold;
    rd_last = (rd_bq.size() > 0) && (rd_idx == rd_bq[0] - 1);
  endtask

  task automatic consume();
    if (exp_wr_gnt) begin
      wr_idx++;
      if (wr_idx == wr_bq[0]) begin void'(wr_bq.pop_front()); wr_idx = 0; end
      wr_addr = rand_addr(); wr_data = $urandom;
    end
    if (exp_rd_gnt) begin
      rd_idx++;
      if (rd_idx == rd_bq[0]) begin void'(rd_bq.pop_front()); rd_idx = 0; end
      rd_addr = rand_addr();
    end
  endtask

  task automatic test_reset();
    ARESET = 1; wr_req = 1; rd_req = 1; wr_last = 1; rd_last = 1;
    wr_addr = 16'h0020; rd_addr = 16'h0024; wr_data = $urandom;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({wr_gnt, rd_gnt, rd_dvalid, mem_en} !== 4'b0000) begin
        errors++; $display("FAIL reset_outputs act=%b exp=0000", {wr_gnt, rd_gnt, rd_dvalid, mem_en});
      end
      checks++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL reset_vec act=%h exp=%h", act_vec(), exp_vec()); end
      advance();
    end
    ARESET = 0;
    settle();
    checks++;
    if ({wr_gnt, rd_gnt} !== 2'b00) begin errors++; $display("FAIL first_cycle_after_reset act=%b exp=00", {wr_gnt, rd_gnt}); end
    advance();
    settle();
    checks++;
    if ({wr_gnt, rd_gnt} !== 2'b10) begin errors++; $display("FAIL post_reset_pref act=%b exp=10", {wr_gnt, rd_gnt}); end
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL post_reset_vec act=%h exp=%h", act_vec(), exp_vec()); end
    advance();
    settle();
    checks++;
    if ({wr_gnt, rd_gnt} !== 2'b01) begin errors++; $display("FAIL alternate_single act=%b exp=01", {wr_gnt, rd_gnt}); end
    advance();
    wr_req = 0; rd_req = 0;
    settle();
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL reset_tail_vec act=%h exp=%h", act_vec(), exp_vec()); end
    advance();
  endtask

  task automatic test_single_write_read();
    wr_req = 1; wr_addr = 16'h0010; wr_data = 32'hDEADBEEF; wr_last = 1; rd_req = 0;
    settle();
    checks++;
    if ({wr_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 10'd4, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_write act=%h exp=%h", {wr_gnt, mem_en, mem_we, mem_addr, mem_wdata},
                         {1'b1, 1'b1, 1'b1, 10'd4, 32'hDEADBEEF});
    end
    advance();
    wr_req = 0; rd_req = 1; rd_addr = 16'h0010; rd_last = 1;
    settle();
    checks++;
    if ({rd_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 10'd4}) begin
      errors++; $display("FAIL single_read act=%h exp=%h", {rd_gnt, mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 10'd4});
    end
    advance();
    rd_req = 0;
    settle();
    checks++;
    if ({rd_dvalid, rd_oor, rd_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_return act=%h exp=%h", {rd_dvalid, rd_oor, rd_data}, {1'b1, 1'b0, 32'hDEADBEEF});
    end
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL read_return_vec act=%h exp=%h", act_vec(), exp_vec()); end
    advance();
  endtask

  task automatic test_contention();
    string seq = "";
    do_reset();
    wr_bq = '{4, 2}; rd_bq = '{4}; wr_idx = 0; rd_idx = 0; wr_hold = 0; rd_hold = 0;
    wr_addr = rand_addr(); rd_addr = rand_addr(); wr_data = $urandom;
    for (int c = 0; c < 30 && (wr_bq.size() > 0 || rd_bq.size() > 0); c++) begin
      drive_engines();
      settle();
      seq = {seq, wr_gnt ? "W" : (rd_gnt ? "R" : "-")};
      checks++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL contention_vec cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec()); end
      advance();
      consume();
    end
    wr_req = 0; rd_req = 0;
    checks++;
    if (seq != "WWWWRRRRWW") begin errors++; $display("FAIL contention_order act=%s exp=WWWWRRRRWW", seq); end
  endtask

  task automatic test_lock_hold();
    string seq = "";
    do_reset();
    wr_bq = '{3}; rd_bq = '{1}; wr_idx = 0; rd_idx = 0; rd_hold = 0;
    for (int c = 0; c < 12 && (wr_bq.size() > 0 || rd_bq.size() > 0); c++) begin
      wr_hold = (c == 1 || c == 2);
      drive_engines();
      settle();
      seq = {seq, wr_gnt ? "W" : (rd_gnt ? "R" : "-")};
      checks++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL lock_hold_vec cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec()); end
      advance();
      consume();
    end
    wr_hold = 0; wr_req = 0; rd_req = 0;
    checks++;
    if (seq != "W--WWR") begin errors++; $display("FAIL lock_hold_order act=%s exp=W--WWR", seq); end
  endtask

  task automatic test_out_of_range();
    wr_req = 1; wr_addr = 16'h1000; wr_data = $urandom; wr_last = 1; rd_req = 0;
    settle();
    checks++;
    if ({wr_gnt, mem_en, wr_oor} !== 3'b101) begin errors++; $display("FAIL oor_write act=%b exp=101", {wr_gnt, mem_en, wr_oor}); end
    advance();
    wr_req = 0; rd_req = 1; rd_addr = 16'h1FFC; rd_last = 1;
    settle();
    checks++;
    if ({rd_gnt, mem_en} !== 2'b10) begin errors++; $display("FAIL oor_read_grant act=%b exp=10", {rd_gnt, mem_en}); end
    advance();
    rd_req = 0;
    settle();
    checks++;
    if ({rd_dvalid, rd_oor, rd_data} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL oor_read_return act=%h exp=%h", {rd_dvalid, rd_oor, rd_data}, {1'b1, 1'b1, 32'h0});
    end
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL oor_vec act=%h exp=%h", act_vec(), exp_vec()); end
    advance();
  endtask

  task automatic test_runaway();
    do_reset();
    rd_req = 1; rd_last = 1; rd_addr = 16'h0040;
    wr_req = 1; wr_last = 0;
    for (int i = 1; i <= 256; i++) begin
      wr_addr = 16'($urandom_range(0, 32'h0FFF)); wr_data = $urandom;
      settle();
      checks++;
      if ({wr_gnt, lock_err} !== {1'b1, (i == 256)}) begin
        errors++; $display("FAIL runaway_beat%0d act=%b exp=%b", i, {wr_gnt, lock_err}, {1'b1, (i == 256)});
      end
      checks++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL runaway_vec beat=%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
      advance();
    end
    settle();
    checks++;
    if ({rd_gnt, wr_gnt, lock_err} !== 3'b100) begin
      errors++; $display("FAIL runaway_handover act=%b exp=100", {rd_gnt, wr_gnt, lock_err});
    end
    advance();
    wr_req = 0; rd_req = 0;
    settle();
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL runaway_tail_vec act=%h exp=%h", act_vec(), exp_vec()); end
    advance();
  endtask

  task automatic test_reset_mid_read();
    wr_req = 0; rd_req = 1; rd_last = 1; rd_addr = 16'h0010;
    settle();
    checks++;
    if (rd_gnt !== 1'b1) begin errors++; $display("FAIL midreset_grant act=%b exp=1", rd_gnt); end
    advance();
    ARESET = 1; wr_req = 1; wr_last = 1; wr_addr = 16'h0008;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({wr_gnt, rd_gnt, rd_dvalid, mem_en} !== 4'b0000) begin
        errors++; $display("FAIL midreset_outputs act=%b exp=0000", {wr_gnt, rd_gnt, rd_dvalid, mem_en});
      end
      advance();
    end
    ARESET = 0;
    settle();
    checks++;
    if ({wr_gnt, rd_gnt, rd_dvalid} !== 3'b000) begin
      errors++; $display("FAIL midreset_first_cycle act=%b exp=000", {wr_gnt, rd_gnt, rd_dvalid});
    end
    advance();
    wr_req = 0; rd_req = 0;
    settle();
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL midreset_vec act=%h exp=%h", act_vec(), exp_vec()); end
    advance();
  endtask

  task automatic test_random();
    int c;
    wr_bq.delete(); rd_bq.delete(); wr_idx = 0; rd_idx = 0;
    for (int i = 0; i < 15; i++) begin
      wr_bq.push_back($urandom_range(1, 6));
      rd_bq.push_back($urandom_range(1, 6));
    end
    wr_addr = rand_addr(); rd_addr = rand_addr(); wr_data = $urandom;
    c = 0;
    while ((wr_bq.size() > 0 || rd_bq.size() > 0) && c < 2000) begin
      wr_hold = ($urandom_range(0, 4) == 0);
      rd_hold = ($urandom_range(0, 4) == 0);
      drive_engines();
      settle();
      checks++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL random_vec cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec()); end
      checks++;
      if ((wr_gnt & rd_gnt) !== 1'b0) begin errors++; $display("FAIL random_exclusive cyc=%0d act=%b exp=0", cyc, wr_gnt & rd_gnt); end
      advance();
      consume();
      c++;
    end
    wr_hold = 0; rd_hold = 0; wr_req = 0; rd_req = 0;
    checks++;
    if (wr_bq.size() + rd_bq.size() != 0) begin
      errors++; $display("FAIL random_drain act=%0d bursts left exp=0", wr_bq.size() + rd_bq.size());
    end
    settle();
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL random_tail_vec act=%h exp=%h", act_vec(), exp_vec()); end
    advance();
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_contention();
    test_lock_hold();
    test_out_of_range();
    test_runaway();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
